// File: rtl/ppu_oam_scan_pkg.sv
// Shared definitions for the PPU OAM-scan stage: object limits, buffer entry layout and
// scan FSM states.
package ppu_oam_scan_pkg;

  localparam int unsigned OBJ_LIMIT = 10;
  localparam int unsigned OAM_OBJS  = 40;

  typedef struct packed {
    logic [7:0] x;
    logic [5:0] oam_idx;
    logic [3:0] row;
  } obj_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } oam_scan_state_t;

endpackage

// File: rtl/ppu_oam_scan_if.sv
// Control, OAM read and object-buffer read signals of the OAM-scan stage.
interface ppu_oam_scan_if;

  logic        start;
  logic [7:0]  ly;
  logic        obj_size;
  logic [6:0]  oam_addr;
  logic [15:0] oam_in;
  logic        busy;
  logic        done;
  logic [3:0]  count;
  logic [3:0]  rd_sel;
  logic [7:0]  rd_x;
  logic [5:0]  rd_oam_idx;
  logic [3:0]  rd_row;

  // The scan block itself.
  modport slave (
    input  start, ly, obj_size, oam_in, rd_sel,
    output oam_addr, busy, done, count, rd_x, rd_oam_idx, rd_row
  );

  // Sequencer, OAM arbiter and draw stage around the scan block.
  modport master (
    output start, ly, obj_size, oam_in, rd_sel,
    input  oam_addr, busy, done, count, rd_x, rd_oam_idx, rd_row
  );

endinterface

// File: rtl/ppu_obj_buffer.sv
// Selected-object register file: one write port, one combinational read port that
// returns zero for entries at or beyond the current count.
module ppu_obj_buffer
  import ppu_oam_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en_i,
  input  logic [3:0] wr_idx_i,
  input  obj_entry_t wr_entry_i,
  input  logic [3:0] count_i,
  input  logic [3:0] rd_sel_i,
  output obj_entry_t rd_entry_o
);

  obj_entry_t mem_q [OBJ_LIMIT];
  obj_entry_t mem_d [OBJ_LIMIT];

  always_comb begin
    for (int k = 0; k < OBJ_LIMIT; k++) begin
      mem_d[k] = mem_q[k];
    end
    if (wr_en_i) begin
      mem_d[wr_idx_i] = wr_entry_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < OBJ_LIMIT; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < OBJ_LIMIT; k++) begin
        mem_q[k] <= mem_d[k];
      end
    end
  end

  // count never exceeds OBJ_LIMIT, so the compare also keeps the index in range.
  always_comb begin
    rd_entry_o = '0;
    if (rd_sel_i < count_i) begin
      rd_entry_o = mem_q[rd_sel_i];
    end
  end

endmodule

// File: rtl/ppu_oam_scan.sv
// OAM scan: walks all 40 OAM entries in 80 dots, two per object, and records up to
// OBJ_LIMIT objects overlapping scanline ly into the object buffer in OAM order.
module ppu_oam_scan
  import ppu_oam_scan_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  ppu_oam_scan_if.slave  bus
);

  oam_scan_state_t state_q, state_d;
  logic [5:0]      idx_q, idx_d;
  logic            phase_q, phase_d;
  logic            size_q, size_d;
  logic [3:0]      count_q, count_d;

  logic            wr_en;
  obj_entry_t      wr_entry;
  obj_entry_t      rd_entry;

  logic [8:0]      t9;
  logic [8:0]      y9;
  logic [8:0]      h9;
  logic            hit;

  // Selection compare, all in 9 bits so Y + height cannot wrap.
  always_comb begin
    t9 = {1'b0, bus.ly} + 9'd16;
    y9 = {1'b0, bus.oam_in[7:0]};
    h9 = size_q ? 9'd16 : 9'd8;
    hit = (y9 <= t9) && (t9 < (y9 + h9));
    wr_entry.x       = bus.oam_in[15:8];
    wr_entry.oam_idx = idx_q;
    wr_entry.row     = 4'(t9 - y9);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    size_d  = size_q;
    count_d = count_q;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = SCAN;
          idx_d   = '0;
          phase_d = 1'b0;
          count_d = '0;
          size_d  = bus.obj_size;
        end
      end
      SCAN: begin
        if (bus.start) begin
          // Restart discards any evaluation in flight this cycle.
          idx_d   = '0;
          phase_d = 1'b0;
          count_d = '0;
          size_d  = bus.obj_size;
        end else if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (hit && (count_q < 4'(OBJ_LIMIT))) begin
            wr_en   = 1'b1;
            count_d = count_q + 4'd1;
          end
          if (idx_q == 6'(OAM_OBJS - 1)) begin
            state_d = DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      phase_q <= 1'b0;
      size_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      size_q  <= size_d;
      count_q <= count_d;
    end
  end

  ppu_obj_buffer u_obj_buffer (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en),
    .wr_idx_i   (count_q),
    .wr_entry_i (wr_entry),
    .count_i    (count_q),
    .rd_sel_i   (bus.rd_sel),
    .rd_entry_o (rd_entry)
  );

  assign bus.oam_addr   = (state_q == SCAN) ? {idx_q, 1'b0} : 7'd0;
  assign bus.busy       = (state_q == SCAN);
  assign bus.done       = (state_q == DONE);
  assign bus.count      = count_q;
  assign bus.rd_x       = rd_entry.x;
  assign bus.rd_oam_idx = rd_entry.oam_idx;
  assign bus.rd_row     = rd_entry.row;

endmodule

// File: tb/tb_ppu_oam_scan.sv
// Bench for ppu_oam_scan: OAM model with 1-cycle read, a per-cycle reference of the
// scan timeline and selection result, and directed literal checks.
module tb_ppu_oam_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ppu_oam_scan_if bus ();

  ppu_oam_scan dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] oam [80];

  always @(posedge clk) bus.oam_in <= oam[bus.oam_addr];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int x;
    int idx;
    int row;
  } ent_t;

  ent_t exp_q[$];
  int   pref [41];
  bit   m_scan = 1'b0;
  bit   m_fin  = 1'b0;
  int   m_pos  = 0;
  bit   chk_on = 1'b0;

  function automatic bit obj_hit(input int y, input int l, input bit sz);
    int t;
    int h;
    t = l + 16;
    h = sz ? 16 : 8;
    return (y <= t) && (t < y + h);
  endfunction

  task automatic build_model();
    int y;
    int x;
    exp_q.delete();
    pref[0] = 0;
    for (int i = 0; i < 40; i++) begin
      y = int'(oam[2*i][7:0]);
      x = int'(oam[2*i][15:8]);
      pref[i+1] = pref[i];
      if (obj_hit(y, int'(bus.ly), bus.obj_size)) begin
        pref[i+1] = pref[i] + 1;
        if (exp_q.size() < 10) exp_q.push_back('{x: x, idx: i, row: (int'(bus.ly) + 16 - y)});
      end
    end
  endtask

  // Scan lasts 80 edges after the start edge; object i's result lands on edge 2i+2.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_scan = 1'b0;
      m_fin  = 1'b0;
    end else if (bus.start) begin
      build_model();
      m_scan = 1'b1;
      m_fin  = 1'b0;
      m_pos  = 0;
    end else if (m_scan) begin
      m_pos++;
      if (m_pos == 80) begin
        m_scan = 1'b0;
        m_fin  = 1'b1;
      end
    end
  end

  function automatic int capped(input int n);
    return (n > 10) ? 10 : n;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      if (m_scan) begin
        chk("busy", 32'(bus.busy), 1);
        chk("done", 32'(bus.done), 0);
        chk("count_mid", 32'(bus.count), 32'(capped(pref[m_pos/2])));
        if (m_pos % 2 == 0) chk("oam_addr", 32'(bus.oam_addr), 32'(m_pos));
      end else if (m_fin) begin
        chk("busy", 32'(bus.busy), 0);
        chk("done", 32'(bus.done), 1);
        chk("count_fin", 32'(bus.count), 32'(capped(pref[40])));
        chk("oam_addr_idle", 32'(bus.oam_addr), 0);
      end else begin
        chk("busy", 32'(bus.busy), 0);
        chk("done", 32'(bus.done), 0);
        chk("count_idle", 32'(bus.count), 0);
        chk("oam_addr_idle", 32'(bus.oam_addr), 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_oam();
    for (int i = 0; i < 40; i++) begin
      oam[2*i]   = 16'h0000;
      oam[2*i+1] = 16'hA500 + 16'(i);
    end
  endtask

  task automatic set_obj(input int i, input int y, input int x);
    logic [7:0] y8;
    logic [7:0] x8;
    y8 = 8'(y);
    x8 = 8'(x);
    oam[2*i] = {x8, y8};
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Returns the number of edges from the start edge until done is seen.
  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_scan(input int l, input bit sz, output int n);
    bus.ly       = 8'(l);
    bus.obj_size = sz;
    pulse_start();
    wait_done(n);
  endtask

  task automatic check_entries();
    for (int s = 0; s < 16; s++) begin
      bus.rd_sel = 4'(s);
      #1;
      if (s < exp_q.size()) begin
        chk("rd_x", 32'(bus.rd_x), 32'(exp_q[s].x));
        chk("rd_oam_idx", 32'(bus.rd_oam_idx), 32'(exp_q[s].idx));
        chk("rd_row", 32'(bus.rd_row), 32'(exp_q[s].row));
      end else begin
        chk("rd_x_zero", 32'(bus.rd_x), 0);
        chk("rd_oam_idx_zero", 32'(bus.rd_oam_idx), 0);
        chk("rd_row_zero", 32'(bus.rd_row), 0);
      end
    end
  endtask

  task automatic read_entry(input int s, output int x, output int idx, output int row);
    bus.rd_sel = 4'(s);
    #1;
    x   = int'(bus.rd_x);
    idx = int'(bus.rd_oam_idx);
    row = int'(bus.rd_row);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n;
    int x;
    int idx;
    int row;
    bus.start    = 1'b0;
    bus.ly       = 8'd0;
    bus.obj_size = 1'b0;
    bus.rd_sel   = 4'd0;
    clear_oam();
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_oam_addr", 32'(bus.oam_addr), 0);
    rst = 1'b0;
    chk_on = 1'b1;
    repeat (2) @(negedge clk);

    // No hits.
    run_scan(50, 1'b0, n);
    chk("nohit_latency", 32'(n), 80);
    chk("nohit_count", 32'(bus.count), 0);
    read_entry(0, x, idx, row);
    chk("nohit_e0", 32'(x + idx + row), 0);
    check_entries();

    // 8-row objects with both row boundaries.
    clear_oam();
    set_obj(3, 16, 40);
    set_obj(7, 9, 77);
    set_obj(9, 8, 55);
    run_scan(0, 1'b0, n);
    chk("b8_latency", 32'(n), 80);
    chk("b8_count", 32'(bus.count), 2);
    read_entry(0, x, idx, row);
    chk("b8_e0_x", 32'(x), 40);
    chk("b8_e0_idx", 32'(idx), 3);
    chk("b8_e0_row", 32'(row), 0);
    read_entry(1, x, idx, row);
    chk("b8_e1_x", 32'(x), 77);
    chk("b8_e1_idx", 32'(idx), 7);
    chk("b8_e1_row", 32'(row), 7);
    check_entries();

    // 16-row object, then same OAM with 8-row size.
    clear_oam();
    set_obj(5, 101, 12);
    run_scan(100, 1'b1, n);
    chk("b16_count", 32'(bus.count), 1);
    read_entry(0, x, idx, row);
    chk("b16_idx", 32'(idx), 5);
    chk("b16_row", 32'(row), 15);
    check_entries();
    run_scan(100, 1'b0, n);
    chk("b16_sz0_count", 32'(bus.count), 0);
    check_entries();

    // Limit: every object hits.
    for (int i = 0; i < 40; i++) set_obj(i, 20, i + 1);
    run_scan(10, 1'b0, n);
    chk("lim_latency", 32'(n), 80);
    chk("lim_count", 32'(bus.count), 10);
    for (int s = 0; s < 10; s++) begin
      read_entry(s, x, idx, row);
      chk("lim_idx", 32'(idx), 32'(s));
    end
    read_entry(12, x, idx, row);
    chk("lim_sel12", 32'(x + idx + row), 0);
    check_entries();

    // Restart mid-scan.
    bus.ly = 8'd10;
    pulse_start();
    repeat (29) @(negedge clk);
    pulse_start();
    wait_done(n);
    chk("restart_latency", 32'(n), 80);
    chk("restart_count", 32'(bus.count), 10);
    check_entries();

    // Asynchronous reset mid-scan.
    pulse_start();
    repeat (44) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_oam_addr", 32'(bus.oam_addr), 0);
    chk("arst_done", 32'(bus.done), 0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_idle", 32'(bus.busy), 0);
    chk("post_rst_done", 32'(bus.done), 0);

    // Scan again after reset with a mix of hits.
    clear_oam();
    set_obj(0, 60, 0);
    set_obj(12, 53, 200);
    set_obj(39, 46, 168);
    set_obj(20, 45, 9);
    run_scan(45, 1'b1, n);
    chk("mix_latency", 32'(n), 80);
    chk("mix_count", 32'(bus.count), 3);
    check_entries();

    @(negedge clk);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ppu_oam_scan.md
# ppu_oam_scan

Object-selection stage of the PPU, directly upstream of the draw/pixel-fetch stage. During the 80-dot OAM-scan phase it walks all 40 OAM entries and records up to 10 objects that intersect the current scanline (`ly`). It stores them, in OAM order, in a small object buffer that the draw stage reads by index. OAM is the 80×16-bit RAM with 1-cycle synchronous read. Word 2i is `{X, Y}` (Y in bits 7:0) and word 2i+1 is `{attr, tile}`. Only even words are read here.

## Interface
Parameters:
- `OBJ_LIMIT`, 10: maximum objects selected per line.
- `OAM_OBJS`, 40: objects walked per scan.

Ports:
- `clk`  in  1  PPU dot clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  one-cycle pulse on the first dot of `PHASE_OAM_SCAN`.
- `ly`  in  8  current scanline, stable for the whole scan.
- `obj_size`  in  1  LCDC.2 (0 = 8-row objects, 1 = 16-row objects); sampled on `start`.
- `oam_addr`  out  7  OAM word address.
- `oam_in`  in  16  OAM read data, valid the cycle after `oam_addr`.
- `busy`  out  1  scan in progress.
- `done`  out  1  scan complete; buffer contents valid.
- `count`  out  4  number of objects selected (0..10).
- `rd_sel`  in  4  buffer entry index, read by the draw stage.
- `rd_x`  out  8  X of the selected entry.
- `rd_oam_idx`  out  6  OAM object index (0..39) of the selected entry.
- `rd_row`  out  4  row within the object for `ly` (0..15).

## Operation
State machine:
- IDLE:
  - `start` → SCAN.
  - `i` ← 0, `count` ← 0, `done` ← 0.
  - `obj_size` is latched.
- SCAN: two cycles per object.
  - Even sub-cycle drives `oam_addr` = 2i.
  - Odd sub-cycle evaluates `oam_in`, then i ← i+1.
  - After object 39's evaluation → DONE.
- DONE:
  - `done`=1, `busy`=0, buffer held.
  - `start` → SCAN (same actions as from IDLE).

Selection rule, with all arithmetic in 9 bits unsigned:
- t = ly + 16.
- h = 16 if the latched size is 1, else 8.
- Hit iff Y ≤ t and t < Y + h.
- `row` = (t − Y)[3:0].
- X is not examined; X=0 and X≥168 objects still count toward the limit.

Buffer writes:
- On a hit with `count` < OBJ_LIMIT, write {X, i, row} to entry `count`, then `count` ← `count`+1.
- Hits after `count`=10 are ignored. The walk still runs to object 39, so timing is constant.

Buffer reads:
- `rd_x`, `rd_oam_idx` and `rd_row` are combinational from `rd_sel`.
- If `rd_sel` ≥ `count`, all three outputs are 0.

Restart and idle behaviour:
- `start` while in SCAN restarts from object 0: count cleared, latch refreshed.
- `oam_addr` = 0 outside SCAN.
- The top-level arbitrates `oam_addr`; this block does not drive a write enable.

Reset values:
- State IDLE.
- `busy`=0, `done`=0, `count`=0, `oam_addr`=0.
- Buffer entries 0.

## Timing
Scan cycles:
- Cycle 0 is the edge on which `start`=1 is sampled.
- Cycles 1..80: `busy`=1.
- Cycle 2i+1 drives `oam_addr`=2i.
- `oam_in` is valid in cycle 2i+2, and the hit is written at the end of that cycle.

Results:
- After the cycle-80 edge, `done`=1 and `count` is final.
- Total: 80 dots after `start`, matching the OAM-scan phase length.
- `count` updates one cycle after each hit evaluation and is visible mid-scan. Consumers use it only when `done`=1.

Reset:
- `rst` asserted at any time, including mid-scan, immediately forces the reset values.
- After `rst` deassert, the block waits for the next `start`.

## Structure
- Shared PPU package holds:
  - `OBJ_LIMIT`, `OAM_OBJS`.
  - `obj_entry_t` packed struct {x[7:0], oam_idx[5:0], row[3:0]}.
  - `oam_scan_state_t` enum {IDLE, SCAN, DONE}.
- Sub-module `ppu_obj_buffer` holds the 10×`obj_entry_t` register file:
  - One write port (en, index, entry) and one combinational read port with the `rd_sel` ≥ `count` zeroing.
  - Clear on `rst`.
- Selection compare stays inline in `ppu_oam_scan`.

## Test plan
- **No hits:** all Y=0, ly=50, start → `done` at cycle 80 with `count`=0; `rd_sel`=0 returns x=0, idx=0, row=0.
- **8-row hit with boundaries:** ly=0, obj_size=0, obj 3 Y=16 X=40, obj 7 Y=9 (t−Y=7), obj 9 Y=8 (t−Y=8, miss) → `count`=2; entry0 = {40, 3, row 0}; entry1 = {X7, 7, row 7}.
- **16-row hit:** obj_size=1, ly=100, obj 5 Y=101 → `count`=1, row=15; same setup with obj_size=0 → `count`=0.
- **Limit:** all 40 objects Y=20, ly=10 → `count`=10; entries hold oam_idx 0..9 in order; `done` still at cycle 80; `rd_sel`=12 reads zeros.
- **Restart and reset:** `start` re-pulsed at cycle 30 → scan restarts and `done` arrives 80 cycles after the second pulse; `rst` at cycle 45 → `busy`=0, `count`=0, `oam_addr`=0 immediately, and the block stays idle until the next `start`.
